// File: rtl/instruction_loader_if.sv
// Byte-stream and instruction-memory bus between the host and the loader.
// The host side (master) drives the framed byte stream and start; the loader
// (slave) returns the handshake, the memory write port and the CPU status.
interface instruction_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  start;
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  we_ins;
  logic [15:0]           load;
  logic [ADDR_WIDTH-1:0] ins_addr;
  logic                  cpu_reset;
  logic                  done;
  logic                  error;

  modport master (
    output start, in_data, in_valid,
    input  in_ready, we_ins, load, ins_addr, cpu_reset, done, error
  );

  modport slave (
    input  start, in_data, in_valid,
    output in_ready, we_ins, load, ins_addr, cpu_reset, done, error
  );
endinterface

// File: rtl/instruction_loader.sv
// Instruction loader: parses a framed byte stream (count N, 2N instruction
// bytes high byte first, XOR checksum byte), writes each 16-bit word into
// instruction memory and holds the processor in reset until a frame with a
// matching checksum has been loaded.
module instruction_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic               clka,
  input  logic               reset,
  instruction_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HI,
    S_LO,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [32:0]           DEPTH    = 33'd1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                r_state;
  state_t                w_next_state;
  logic                  w_in_ready;
  logic                  w_accept;

  logic                  r_we_ins;
  logic [15:0]           r_load;
  logic [ADDR_WIDTH-1:0] r_ins_addr;
  logic                  r_cpu_reset;
  logic                  r_done;
  logic                  r_error;
  logic [7:0]            r_checksum;
  logic [7:0]            r_remaining;

  // A count larger than the memory depth cannot be stored without wrapping.
  function automatic logic f_count_overflow(input logic [7:0] count);
    f_count_overflow = ({25'd0, count} > DEPTH);
  endfunction

  // Frame state register.
  always_ff @(posedge clka or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode, Moore ready and byte-accept qualification.
  always_comb begin
    w_next_state = r_state;
    w_in_ready   = 1'b0;
    w_accept     = 1'b0;

    case (r_state)
      S_IDLE, S_HI, S_LO, S_CHECK: w_in_ready = 1'b1;
      default:                     w_in_ready = 1'b0;
    endcase

    // start takes the byte slot away so a concurrent byte is never consumed.
    w_accept = bus.in_valid & w_in_ready & ~bus.start;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (bus.in_data == 8'd0) begin
            w_next_state = S_CHECK;
          end else if (f_count_overflow(bus.in_data)) begin
            w_next_state = S_ERROR;
          end else begin
            w_next_state = S_HI;
          end
        end
      end
      S_HI: begin
        if (w_accept) begin
          w_next_state = S_LO;
        end
      end
      S_LO: begin
        if (w_accept) begin
          w_next_state = S_WRITE;
        end
      end
      S_WRITE: begin
        w_next_state = (r_remaining == 8'd1) ? S_CHECK : S_HI;
      end
      S_CHECK: begin
        if (w_accept) begin
          w_next_state = (bus.in_data == r_checksum) ? S_DONE : S_ERROR;
        end
      end
      S_DONE:  w_next_state = S_DONE;
      S_ERROR: w_next_state = S_ERROR;
      default: w_next_state = S_IDLE;
    endcase

    if (bus.start) begin
      w_next_state = S_IDLE;
    end
  end

  // Word assembly, checksum accumulation, address/count tracking and
  // registered status outputs (decoded from the state being entered).
  always_ff @(posedge clka or negedge reset) begin
    if (!reset) begin
      r_we_ins    <= 1'b0;
      r_load      <= 16'd0;
      r_ins_addr  <= '0;
      r_cpu_reset <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_checksum  <= 8'd0;
      r_remaining <= 8'd0;
    end else begin
      r_we_ins    <= (w_next_state == S_WRITE);
      r_cpu_reset <= (w_next_state != S_DONE);
      r_done      <= (w_next_state == S_DONE);
      r_error     <= (w_next_state == S_ERROR);

      if (bus.start) begin
        r_ins_addr  <= '0;
        r_checksum  <= 8'd0;
        r_remaining <= 8'd0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_remaining <= bus.in_data;
              r_checksum  <= bus.in_data;
              r_ins_addr  <= '0;
            end
          end
          S_HI: begin
            if (w_accept) begin
              r_load[15:8] <= bus.in_data;
              r_checksum   <= r_checksum ^ bus.in_data;
            end
          end
          S_LO: begin
            if (w_accept) begin
              r_load[7:0] <= bus.in_data;
              r_checksum  <= r_checksum ^ bus.in_data;
            end
          end
          S_WRITE: begin
            r_ins_addr  <= r_ins_addr + ADDR_ONE;
            r_remaining <= r_remaining - 8'd1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.we_ins    = r_we_ins;
  assign bus.load      = r_load;
  assign bus.ins_addr  = r_ins_addr;
  assign bus.cpu_reset = r_cpu_reset;
  assign bus.done      = r_done;
  assign bus.error     = r_error;

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader: directed frames, a write
// scoreboard popped by a monitor on every we_ins pulse, and status checks.
module tb_instruction_loader;

  localparam int AW = 8;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  logic clka;
  logic rst_n;
  int   tests;
  int   fails;
  int   hs_cnt;

  wr_t        exp_q[$];
  logic [7:0] frame_q[$];

  instruction_loader_if #(.ADDR_WIDTH(AW)) bus ();

  instruction_loader #(.ADDR_WIDTH(AW)) dut (
    .clka  (clka),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Write monitor: every we_ins pulse must match the oldest expected write.
  always @(negedge clka) begin
    if (bus.we_ins) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: addr 0x%0h load 0x%0h, no write expected",
                 bus.ins_addr, bus.load);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (bus.ins_addr !== e.addr || bus.load !== e.data) begin
          fails++;
          $display("FAIL write: addr 0x%0h load 0x%0h expected addr 0x%0h load 0x%0h",
                   bus.ins_addr, bus.load, e.addr, e.data);
        end
      end
    end
    if (rst_n && bus.in_valid && bus.in_ready && !bus.start) hs_cnt++;
  end

  task automatic push_wr(input logic [AW-1:0] a, input logic [15:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Called aligned at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    @(negedge clka);
    while (!bus.in_ready && n < 20) begin
      n++;
      @(negedge clka);
    end
    if (!bus.in_ready) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: in_ready 0 expected 1 within 20 cycles");
    end
    @(posedge clka);
    #1;
  endtask

  task automatic send_frame(input bit gap);
    foreach (frame_q[i]) begin
      send_byte(frame_q[i]);
      if (gap) begin
        bus.in_valid = 1'b0;
        @(posedge clka);
        #1;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic load_good_frame();
    frame_q = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
  endtask

  task automatic pulse_start();
    @(posedge clka);
    #1;
    bus.start    = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clka);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clka);
    rst_n = 1'b1;
    @(posedge clka);
    #1;
  endtask

  task automatic check_status(input string tag, input logic d, input logic e,
                              input logic cr, input logic rdy);
    @(negedge clka);
    check({tag, "_done"},      {31'd0, bus.done},      {31'd0, d});
    check({tag, "_error"},     {31'd0, bus.error},     {31'd0, e});
    check({tag, "_cpu_reset"}, {31'd0, bus.cpu_reset}, {31'd0, cr});
    check({tag, "_in_ready"},  {31'd0, bus.in_ready},  {31'd0, rdy});
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_we_ins"},    {31'd0, bus.we_ins},    32'd0);
    check({tag, "_load"},      {16'd0, bus.load},      32'd0);
    check({tag, "_ins_addr"},  {24'd0, bus.ins_addr},  32'd0);
    check({tag, "_cpu_reset"}, {31'd0, bus.cpu_reset}, 32'd1);
    check({tag, "_done"},      {31'd0, bus.done},      32'd0);
    check({tag, "_error"},     {31'd0, bus.error},     32'd0);
    check({tag, "_in_ready"},  {31'd0, bus.in_ready},  32'd1);
  endtask

  initial begin
    tests        = 0;
    fails        = 0;
    hs_cnt       = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;

    // Reset state
    repeat (2) @(negedge clka);
    check_reset_values("rst");
    rst_n = 1'b1;
    @(posedge clka);
    #1;

    // Good frame, continuous valid
    load_good_frame();
    push_wr(8'd0, 16'h1234);
    push_wr(8'd1, 16'hABCD);
    send_frame(1'b0);
    check_status("good", 1'b1, 1'b0, 1'b0, 1'b0);
    check("good_writes_left", exp_q.size(), 32'd0);

    // Bad checksum, then recovery by start
    pulse_start();
    frame_q = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
    push_wr(8'd0, 16'h1234);
    push_wr(8'd1, 16'hABCD);
    send_frame(1'b0);
    check_status("badck", 1'b0, 1'b1, 1'b1, 1'b0);
    check("badck_writes_left", exp_q.size(), 32'd0);
    pulse_start();
    check_status("badck_start", 1'b0, 1'b0, 1'b1, 1'b1);

    // Empty frame after reset release
    do_reset();
    frame_q = '{8'h00, 8'h00};
    send_frame(1'b0);
    check_status("empty", 1'b1, 1'b0, 1'b0, 1'b0);

    // Empty frame with wrong checksum
    pulse_start();
    frame_q = '{8'h00, 8'h01};
    send_frame(1'b0);
    check_status("empty_bad", 1'b0, 1'b1, 1'b1, 1'b0);

    // Good frame with in_valid toggling every cycle
    pulse_start();
    hs_cnt = 0;
    load_good_frame();
    push_wr(8'd0, 16'h1234);
    push_wr(8'd1, 16'hABCD);
    send_frame(1'b1);
    check_status("gap", 1'b1, 1'b0, 1'b0, 1'b0);
    check("gap_handshakes", hs_cnt, 32'd6);
    check("gap_writes_left", exp_q.size(), 32'd0);

    // Asynchronous reset after the first word is written
    pulse_start();
    push_wr(8'd0, 16'h1234);
    send_byte(8'h02);
    send_byte(8'h12);
    send_byte(8'h34);
    bus.in_valid = 1'b0;
    @(posedge clka);
    #1;
    check("pre_async_addr", {24'd0, bus.ins_addr}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async");
    check("async_writes_left", exp_q.size(), 32'd0);
    @(negedge clka);
    rst_n = 1'b1;
    @(posedge clka);
    #1;
    load_good_frame();
    push_wr(8'd0, 16'h1234);
    push_wr(8'd1, 16'hABCD);
    send_frame(1'b0);
    check_status("reload", 1'b1, 1'b0, 1'b0, 1'b0);

    // start while in LO with a byte presented
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h12);
    bus.in_data  = 8'h34;
    bus.in_valid = 1'b1;
    bus.start    = 1'b1;
    @(posedge clka);
    #1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clka);
    check("lo_start_ready", {31'd0, bus.in_ready}, 32'd1);
    check("lo_start_we",    {31'd0, bus.we_ins},   32'd0);
    @(posedge clka);
    #1;
    load_good_frame();
    push_wr(8'd0, 16'h1234);
    push_wr(8'd1, 16'hABCD);
    send_frame(1'b0);
    check_status("lo_start", 1'b1, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clka);
    check("final_writes_left", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
